// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that shares one registered NAND/AND/OR/XOR unit among NUM_REQ requesters.
// Each transaction runs IDLE (grant) -> EXEC (evaluate) -> RESP (hold until taken).
module gate_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [2*NUM_REQ-1:0]        req_op_i,
  input  logic [WIDTH*NUM_REQ-1:0]    req_a_i,
  input  logic [WIDTH*NUM_REQ-1:0]    req_b_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
  output logic [WIDTH-1:0]            rsp_y_o,
  output logic                        busy_o,
  output logic [15:0]                 done_cnt_o
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IDW-1:0]   rid_q, rid_d;
  logic             vld_q, vld_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      done_cnt_q;

  logic             found;
  logic [IDW-1:0]   win;
  int               idx;

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    y_d     = y_q;
    rid_d   = rid_q;
    vld_d   = vld_q;
    cnt_d   = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          op_d    = req_op_i[2*int'(win) +: 2];
          a_d     = req_a_i[WIDTH*int'(win) +: WIDTH];
          b_d     = req_b_i[WIDTH*int'(win) +: WIDTH];
          id_d    = win;
          ptr_d   = win;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          2'b00:   y_d = ~(a_q & b_q);
          2'b01:   y_d = a_q & b_q;
          2'b10:   y_d = a_q | b_q;
          default: y_d = a_q ^ b_q;
        endcase
        rid_d   = id_q;
        vld_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          vld_d   = 1'b0;
          cnt_d   = (done_cnt_q == 16'hFFFF) ? done_cnt_q : done_cnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDW'(NUM_REQ - 1);
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      y_q        <= '0;
      rid_q      <= '0;
      vld_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      y_q        <= y_d;
      rid_q      <= rid_d;
      vld_q      <= vld_d;
      done_cnt_q <= cnt_d;
    end
  end

  assign cnt_q       = done_cnt_q;
  assign req_ready_o = (state_q == ST_IDLE && !rst_i && found) ? (NUM_REQ'(1) << win) : '0;
  assign rsp_valid_o = vld_q;
  assign rsp_id_o    = rid_q;
  assign rsp_y_o     = y_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_cnt_o  = done_cnt_q;
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_gate_unit_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [2*NR-1:0]   req_op;
  logic [W*NR-1:0]   req_a, req_b;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_y;
  logic              busy;
  logic [15:0]       done_cnt;

  int errors = 0;
  int checks = 0;

  // model: phase 0 waiting for grant, 1 evaluating, 2 holding response
  int         m_phase, m_ptr, m_id, m_rid;
  logic [1:0] m_op;
  logic [W-1:0] m_a, m_b, m_y;
  logic       m_vld;
  logic [15:0] m_cnt;

  gate_unit_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_y_o(rsp_y), .busy_o(busy), .done_cnt_o(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gate_f(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'd0:    return ~(a & b);
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic int winner();
    for (int k = 1; k <= NR; k++)
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] exp_ready();
    int w;
    w = winner();
    if (rst || m_phase != 0 || w < 0) return '0;
    return NR'(1) << w;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_phase = 0; m_ptr = NR - 1; m_vld = 1'b0; m_y = '0; m_rid = 0; m_cnt = '0;
    end else if (m_phase == 0) begin
      w = winner();
      if (w >= 0) begin
        m_op = req_op[2*w +: 2]; m_a = req_a[W*w +: W]; m_b = req_b[W*w +: W];
        m_id = w; m_ptr = w; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_y = gate_f(m_op, m_a, m_b); m_rid = m_id; m_vld = 1'b1; m_phase = 2;
    end else if (rsp_ready) begin
      m_vld = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_phase = 0;
    end
  endtask

  // Called at a negedge with inputs already driven; checks, crosses one edge, returns at next negedge.
  task automatic cycle();
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
    chk("rsp_y", 32'(rsp_y), 32'(m_y));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[2*i +: 2] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  // Single requester transaction; checks result value, id and two-cycle latency.
  task automatic run_one(input int id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_y);
    int acc_at;
    bit acc, got;
    acc_at = -1; got = 0;
    req_valid = '0; req_valid[id] = 1'b1; set_req(id, op, a, b); rsp_ready = 1'b1;
    for (int n = 0; n < 12 && !got; n++) begin
      #1;
      if (rsp_valid) begin
        chk("op_result", 32'(rsp_y), 32'(exp_y));
        chk("op_id", 32'(rsp_id), 32'(id));
        chk("latency", 32'(n - acc_at), 32'd2);
        got = 1;
        cycle();
      end else begin
        acc = req_ready[id];
        if (acc) acc_at = n;
        cycle();
        if (acc) req_valid = '0;
      end
    end
    if (!got) chk("op_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] c0;
    logic [W-1:0] y0;
    logic [1:0] id0;
    int ids[$];
    int at[$];
    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_phase = 0; m_ptr = NR - 1; m_id = 0; m_rid = 0; m_op = '0; m_a = '0; m_b = '0;
    m_y = '0; m_vld = 1'b0; m_cnt = '0;
    @(negedge clk);
    req_valid = 4'b1111;
    do_reset(2);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1; #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0; req_valid = '0;
    @(negedge clk);

    // gate functions, full width and single-bit truth table
    run_one(0, 2'd0, 8'h0F, 8'h3C, 8'hF3);
    chk("done_after_first", 32'(done_cnt), 32'd1);
    run_one(0, 2'd1, 8'h0F, 8'h3C, 8'h0C);
    run_one(0, 2'd2, 8'h0F, 8'h3C, 8'h3F);
    run_one(0, 2'd3, 8'h0F, 8'h3C, 8'h33);
    for (int op = 0; op < 4; op++)
      for (int ab = 0; ab < 4; ab++)
        run_one(op, 2'(op), W'(ab >> 1), W'(ab & 1), gate_f(2'(op), W'(ab >> 1), W'(ab & 1)));

    // strict fairness with all requesters valid
    do_reset(1);
    for (int i = 0; i < NR; i++) set_req(i, 2'(i), W'(8'h11 * (i + 1)), 8'hA5);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int n = 0; n < 18; n++) begin
      #1;
      if (rsp_valid) begin ids.push_back(int'(rsp_id)); at.push_back(n); end
      cycle();
    end
    req_valid = '0;
    chk("rr_count", 32'(ids.size()), 32'd6);
    for (int i = 0; i < 6 && i < ids.size(); i++) begin
      chk("rr_id", 32'(ids[i]), 32'(exp_ids[i]));
      if (i > 0) chk("rr_spacing", 32'(at[i] - at[i-1]), 32'd3);
    end
    while (m_phase != 0) cycle();

    // response stall: outputs frozen, nobody else granted
    rsp_ready = 1'b0; req_valid = 4'b0010; set_req(1, 2'd3, 8'h5A, 8'hFF);
    for (int n = 0; n < 8 && !rsp_valid; n++) begin
      #1; cycle();
      if (!req_ready[1]) req_valid = 4'b1111;
    end
    c0 = done_cnt; y0 = rsp_y; id0 = rsp_id;
    chk("stall_start_valid", 32'(rsp_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("stall_y", 32'(rsp_y), 32'(y0));
      chk("stall_id", 32'(rsp_id), 32'(id0));
    end
    chk("stall_val", 32'(y0), 32'h00A5);
    req_valid = '0; rsp_ready = 1'b1;
    cycle();
    chk("stall_release_cnt", 32'(done_cnt), 32'(c0 + 16'd1));
    chk("stall_release_valid", 32'(rsp_valid), 32'd0);

    // reset during EXEC drops the transaction and restores priority to req 0
    req_valid = 4'b0010; set_req(1, 2'd1, 8'hFF, 8'hFF);
    cycle();
    req_valid = '0;
    chk("exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
    chk("rst_exec_busy", 32'(busy), 32'd0);
    chk("rst_exec_cnt", 32'(done_cnt), 32'd0);
    req_valid = 4'b1111; #1;
    chk("rst_exec_prio", 32'(req_ready), 32'b0001);
    req_valid = '0;
    cycle();

    // wrap-around search and counter saturation
    run_one(3, 2'd2, 8'h80, 8'h01, 8'h81);
    req_valid = 4'b0100; #1;
    chk("wrap_grant", 32'(req_ready), 32'b0100);
    dut.done_cnt_q = 16'hFFFE; m_cnt = 16'hFFFE;
    run_one(2, 2'd0, 8'hFF, 8'h00, 8'hFF);
    chk("sat_fffe", 32'(done_cnt), 32'hFFFF);
    run_one(1, 2'd3, 8'hAA, 8'h55, 8'hFF);
    chk("sat_hold", 32'(done_cnt), 32'hFFFF);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      req_valid = NR'($urandom);
      req_op = 8'($urandom);
      req_a = $urandom;
      req_b = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
